// File: rtl/sha_sched_pkg.sv
// sha_sched_pkg: shared types and constants for the SHA-2 message scheduler.
//   state_t              : scheduler FSM states
//   word_w_ok()          : legal word-width check (32 or 64)
//   rot_a/rot_b/shr_n()  : sigma rotate/shift amounts keyed by word width and
//                          sigma select (0 = sigma0, 1 = sigma1)
package sha_sched_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic bit word_w_ok(input int w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic int rot_a(input int w, input int sel);
    if (w == 64) return (sel != 0) ? 19 : 1;
    return (sel != 0) ? 17 : 7;
  endfunction

  function automatic int rot_b(input int w, input int sel);
    if (w == 64) return (sel != 0) ? 61 : 8;
    return (sel != 0) ? 19 : 18;
  endfunction

  function automatic int shr_n(input int w, input int sel);
    if (w == 64) return (sel != 0) ? 6 : 7;
    return (sel != 0) ? 10 : 3;
  endfunction

endpackage

// File: rtl/sha_sigma.sv
// sha_sigma: combinational SHA-2 small sigma function.
//   WORD_W : 32 (SHA-256 family) or 64 (SHA-512 family)
//   SEL    : 0 = sigma0, 1 = sigma1
// Ports:
//   x : input word
//   y : ROTR(a) ^ ROTR(b) ^ SHR(c) of x
module sha_sigma
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL    = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam int RA = rot_a(WORD_W, SEL);
  localparam int RB = rot_b(WORD_W, SEL);
  localparam int SH = shr_n(WORD_W, SEL);

  assign y = ((x >> RA) | (x << (WORD_W - RA))) ^
             ((x >> RB) | (x << (WORD_W - RB))) ^
             (x >> SH);

endmodule

// File: rtl/sha_msg_sched.sv
// sha_msg_sched: streaming SHA-2 message-schedule generator.
// Accepts one padded 16-word block and emits W[0..ROUNDS-1] one word per
// valid/ready handshake, using a 16-word sliding window.
// Parameters: WORD_W (32/64), ROUNDS (>=16), IDX_W (derived).
// Ports:
//   clock, reset (async active-low), flush (sync abort)
//   block_valid/block_ready/block_data : block input, word 0 in the MSBs
//   w_valid/w_ready/w_word/w_index/w_last : schedule word output
// Optional (macro SHA_SCHED_VECTOR_EN):
//   w_vector          : all handshaken words, word t at [t*WORD_W +: WORD_W]
//   w_vector_complete : one-cycle pulse after the last word's handshake
module sha_msg_sched
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   block_valid,
  output logic                   block_ready,
  input  logic [16*WORD_W-1:0]   block_data,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [WORD_W-1:0]      w_word,
  output logic [IDX_W-1:0]       w_index,
  output logic                   w_last
`ifdef SHA_SCHED_VECTOR_EN
  ,
  output logic [ROUNDS*WORD_W-1:0] w_vector,
  output logic                     w_vector_complete
`endif
);

  if (!word_w_ok(WORD_W)) begin : g_bad_word_w
    $error("sha_msg_sched: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16) begin : g_bad_rounds
    $error("sha_msg_sched: ROUNDS must be at least 16");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  state_t                   state;
  logic [15:0][WORD_W-1:0]  win;     // win[0] is the word currently offered
  logic [IDX_W-1:0]         count;
  logic [WORD_W-1:0]        s0, s1, w_new;
  logic                     hs;

  sha_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (.x(win[1]),  .y(s0));
  sha_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (.x(win[14]), .y(s1));

  // W[t+16] from the window holding W[t..t+15]
  assign w_new = s1 + win[9] + s0 + win[0];

  assign hs          = (state == RUN) && w_ready;
  assign block_ready = (state == IDLE);
  assign w_valid     = (state == RUN);
  assign w_word      = w_valid ? win[0] : '0;
  assign w_index     = count;
  assign w_last      = w_valid && (count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      win   <= '0;
      count <= '0;
    end else if (flush) begin
      // flush wins over both a pending handshake and a block load
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (block_valid) begin
          for (int i = 0; i < 16; i++)
            win[i] <= block_data[(16-i)*WORD_W-1 -: WORD_W];
          count <= '0;
          state <= RUN;
        end
        RUN: if (w_ready) begin
          win <= {w_new, win[15:1]};
          if (count == LAST) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA_SCHED_VECTOR_EN
  logic [ROUNDS-1:0][WORD_W-1:0] vec;
  logic                          vec_done;

  assign w_vector          = vec;
  assign w_vector_complete = vec_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vec      <= '0;
      vec_done <= 1'b0;
    end else begin
      vec_done <= 1'b0;
      if (!flush) begin
        if (state == IDLE && block_valid) vec <= '0;
        if (hs) begin
          vec[count] <= win[0];
          vec_done   <= (count == LAST);
        end
      end
    end
  end
`endif

endmodule
